// File: rtl/demux_by_2_buf.sv
// Registered 1-to-2 demultiplexer: in_sel steers each producer word into one
// of two independent 2-entry FIFOs, each with its own valid/ready consumer.
module demux_by_2_buf_fifo #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [N-1:0] push_data,
    input  logic         ready,
    output logic         valid,
    output logic [N-1:0] data,
    output logic [1:0]   count
);
    localparam int unsigned CW = 2;

    logic [N-1:0]  head_q, head_d;
    logic [N-1:0]  tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;

    assign valid = (cnt_q != CW'(0));
    assign data  = valid ? head_q : N'(0);
    assign count = cnt_q;
    assign pop   = valid & ready;

    // Next-state for head/tail/count; push+pop only reachable at count 1.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == CW'(0)) begin
                    head_d = push_data;
                    cnt_d  = CW'(1);
                end else if (cnt_q == CW'(1)) begin
                    tail_d = push_data;
                    cnt_d  = CW'(2);
                end
            end
            2'b01: begin
                if (cnt_q == CW'(2)) begin
                    head_d = tail_q;
                    cnt_d  = CW'(1);
                end else begin
                    cnt_d  = CW'(0);
                end
            end
            2'b11: begin
                head_d = push_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module demux_by_2_buf #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_sel,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out0_valid,
    output logic [N-1:0] out0_data,
    input  logic         out0_ready,
    output logic         out1_valid,
    output logic [N-1:0] out1_data,
    input  logic         out1_ready,
    output logic [1:0]   count0,
    output logic [1:0]   count1
);
    logic push0, push1;

    // Ready depends only on the addressed FIFO, so a stalled output never blocks the other.
    assign in_ready = (in_sel ? count1 : count0) != 2'd2;
    assign push0    = in_valid & in_ready & ~in_sel;
    assign push1    = in_valid & in_ready & in_sel;

    demux_by_2_buf_fifo #(.N(N)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .ready     (out0_ready),
        .valid     (out0_valid),
        .data      (out0_data),
        .count     (count0)
    );

    demux_by_2_buf_fifo #(.N(N)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .ready     (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data),
        .count     (count1)
    );
endmodule

// File: tb/tb_demux_by_2_buf.sv
// Directed and random-stream checks for demux_by_2_buf against a queue model.
module tb_demux_by_2_buf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sel, in_ready;
    logic [31:0] in_data;
    logic        out0_valid, out0_ready, out1_valid, out1_ready;
    logic [31:0] out0_data, out1_data;
    logic [1:0]  count0, count1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux_by_2_buf #(.N(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .count0     (count0),
        .count1     (count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q0[$];
        logic [31:0] q1[$];
        logic        exp_rdy, acc, p0, p1;
        int          sent, cyc;

        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #12;
        chk("rst_count0", 32'(count0), 0);
        chk("rst_count1", 32'(count1), 0);
        chk("rst_valid0", 32'(out0_valid), 0);
        chk("rst_valid1", 32'(out1_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // basic steering
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA5A5A5A5;
        #1 chk("steer_rdy", 32'(in_ready), 1);
        tick();
        chk("steer_v0", 32'(out0_valid), 1);
        chk("steer_d0", out0_data, 32'hA5A5A5A5);
        chk("steer_d1_zero", out1_data, 0);
        in_sel = 1'b1; in_data = 32'h5A5A5A5A;
        tick();
        chk("steer_v0_gone", 32'(out0_valid), 0);
        chk("steer_d0_zero", out0_data, 0);
        chk("steer_d1", out1_data, 32'h5A5A5A5A);
        in_valid = 1'b0;
        tick();
        chk("steer_v1_gone", 32'(out1_valid), 0);

        // fill and backpressure
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd1;
        tick();
        in_data = 32'd2;
        tick();
        in_data = 32'd3;
        #1 chk("fill_cnt2", 32'(count0), 2);
        chk("fill_rdy_low", 32'(in_ready), 0);
        tick();
        chk("fill_hold_cnt", 32'(count0), 2);
        chk("fill_head1", out0_data, 32'd1);
        out0_ready = 1'b1;
        tick();
        chk("fill_head2", out0_data, 32'd2);
        chk("fill_cnt_after_pop", 32'(count0), 1);
        chk("fill_rdy_up", 32'(in_ready), 1);
        tick();
        chk("fill_head3", out0_data, 32'd3);
        chk("fill_cnt_pp", 32'(count0), 1);
        in_valid = 1'b0;
        tick();
        chk("fill_empty", 32'(count0), 0);

        // isolation: output 0 full and stalled
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_data = 32'hC;
        #1 chk("iso_rdy0_low", 32'(in_ready), 0);
        in_sel = 1'b1; in_data = 32'h11;
        #1 chk("iso_rdy1_high", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("iso_v1", 32'(out1_valid), 1);
        chk("iso_d1", out1_data, 32'h11);
        chk("iso_cnt0", 32'(count0), 2);
        chk("iso_head0", out0_data, 32'hA);

        // asynchronous reset mid-stream with count0=2
        rst_n = 1'b0; in_sel = 1'b0;
        #1 chk("arst_v0", 32'(out0_valid), 0);
        chk("arst_d0", out0_data, 0);
        chk("arst_cnt0", 32'(count0), 0);
        chk("arst_cnt1", 32'(count1), 0);
        chk("arst_rdy", 32'(in_ready), 1);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // simultaneous push and pop at count 1
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h10;
        tick();
        out0_ready = 1'b1; in_data = 32'h20;
        #1 chk("pp_head_before", out0_data, 32'h10);
        tick();
        chk("pp_head_after", out0_data, 32'h20);
        chk("pp_cnt", 32'(count0), 1);
        in_valid = 1'b0;
        tick();
        chk("pp_drained", 32'(count0), 0);

        // random streaming against queue model
        sent = 0; cyc = 0;
        while ((sent < 100 || q0.size() != 0 || q1.size() != 0 || in_valid) && cyc < 3000) begin
            cyc++;
            if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            out0_ready = (sent >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
            out1_ready = (sent >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            exp_rdy = in_sel ? (q1.size() != 2) : (q0.size() != 2);
            chk("st_rdy", 32'(in_ready), 32'(exp_rdy));
            chk("st_cnt0", 32'(count0), 32'(q0.size()));
            chk("st_cnt1", 32'(count1), 32'(q1.size()));
            chk("st_v0", 32'(out0_valid), 32'(q0.size() != 0));
            chk("st_v1", 32'(out1_valid), 32'(q1.size() != 0));
            chk("st_d0", out0_data, (q0.size() != 0) ? q0[0] : 32'd0);
            chk("st_d1", out1_data, (q1.size() != 0) ? q1[0] : 32'd0);
            p0  = (q0.size() != 0) && out0_ready;
            p1  = (q1.size() != 0) && out1_ready;
            acc = in_valid && exp_rdy;
            tick();
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (acc) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("st_completed", 32'(cyc < 3000), 1);
        chk("st_sent", 32'(sent), 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
